unidad_fetch: RTL and testbench

Instruction fetch unit that produces the 32-bit instruction word consumed by the datapath on its instruction input (opcode [31:26], rs [25:21], rt [20:16], rd [15:11], funct [5:0]).
It holds the PC and issues word reads to a synchronous instruction memory with 1-cycle read latency.
Returned words are buffered in a 2-entry FIFO and presented to the datapath through a valid/ready handshake.
It supports redirect (branch/jump) with flush of buffered and in-flight words, plus a halt input.

---
 rtl/unidad_fetch_pkg.sv | 18 +
 rtl/unidad_fetch_fifo.sv | 86 ++++++++
 rtl/unidad_fetch.sv | 88 ++++++++
 tb/tb_unidad_fetch.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/unidad_fetch_pkg.sv
// Shared constants for the instruction fetch unit: instruction width,
// instruction field bit positions and the reset/bubble instruction value.
package unidad_fetch_pkg;

  localparam int INSTR_W   = 32;

  // Instruction field boundaries (MIPS-style encoding)
  localparam int OPCODE_HI = 31;
  localparam int OPCODE_LO = 26;
  localparam int RS_LO     = 21;
  localparam int RT_LO     = 16;
  localparam int RD_LO     = 11;
  localparam int FUNCT_LO  = 0;

  // Value presented on the instruction output when nothing was ever loaded
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

endpackage : unidad_fetch_pkg

// File: rtl/unidad_fetch_fifo.sv
// Two-entry FIFO of {instruction, pc} pairs with a registered head.
// Flush empties the FIFO and wins over a simultaneous push.
module fifo_instr
  import unidad_fetch_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               push,
  input  logic [INSTR_W-1:0] push_instr,
  input  logic [ADDR_W-1:0]  push_pc,
  input  logic               pop,
  output logic [INSTR_W-1:0] head_instr,
  output logic [ADDR_W-1:0]  head_pc,
  output logic               head_valid,
  output logic [1:0]         count
);

  logic [INSTR_W-1:0] instr_q [2];
  logic [INSTR_W-1:0] instr_d [2];
  logic [ADDR_W-1:0]  pc_q    [2];
  logic [ADDR_W-1:0]  pc_d    [2];
  logic               wr_ptr_q, wr_ptr_d;
  logic               rd_ptr_q, rd_ptr_d;
  logic [1:0]         count_q, count_d;

  // Pointer and occupancy update; flush resets both pointers
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (push) wr_ptr_d = ~wr_ptr_q;
      if (pop)  rd_ptr_d = ~rd_ptr_q;
      count_d = count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  // Control state register
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Per-entry storage; an entry loads only when it is the write target
  for (genvar gi = 0; gi < 2; gi++) begin : g_entry
    logic we;

    // Select new contents for this entry
    always_comb begin
      we          = push & ~flush & (wr_ptr_q == 1'(gi));
      instr_d[gi] = we ? push_instr : instr_q[gi];
      pc_d[gi]    = we ? push_pc    : pc_q[gi];
    end

    // Entry register; reset value makes the head read as zero
    always_ff @(posedge clk) begin
      if (rst) begin
        instr_q[gi] <= NOP_INSTR;
        pc_q[gi]    <= '0;
      end else begin
        instr_q[gi] <= instr_d[gi];
        pc_q[gi]    <= pc_d[gi];
      end
    end
  end

  assign head_instr = instr_q[rd_ptr_q];
  assign head_pc    = pc_q[rd_ptr_q];
  assign head_valid = (count_q != 2'd0);
  assign count      = count_q;

endmodule : fifo_instr

// File: rtl/unidad_fetch.sv
// Instruction fetch unit: PC register, credit-based request issue to a
// 1-cycle-latency instruction memory, kill of stale responses on redirect,
// and a 2-entry output FIFO with a valid/ready handshake.
module unidad_fetch
  import unidad_fetch_pkg::*;
#(
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_rd_en,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [INSTR_W-1:0] instr_out,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  input  logic               halt
);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] issue_pc_q, issue_pc_d;
  logic              inflight_q, inflight_d;
  logic              pop;
  logic              push;
  logic              issue;
  logic [1:0]        count;
  logic [2:0]        credit;

  // Handshake and credit: a request may go out only if its response is
  // guaranteed a FIFO slot, counting words already buffered or in flight
  always_comb begin
    pop    = instr_valid & instr_ready & ~redirect;
    credit = {1'b0, count} + {2'b00, inflight_q} - {2'b00, pop};
    issue  = ~rst & ~halt & ~redirect & (credit < 3'd2);
    // A redirect flushes the FIFO, which also drops the response arriving now
    push   = inflight_q & ~redirect;
  end

  // Next PC, in-flight flag and the address of the outstanding request
  always_comb begin
    pc_d       = pc_q;
    inflight_d = issue;
    issue_pc_d = issue_pc_q;
    if (redirect) begin
      pc_d = redirect_pc;
    end else if (issue) begin
      pc_d       = pc_q + 1'b1;
      issue_pc_d = pc_q;
    end
  end

  // Fetch state register
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      inflight_q <= 1'b0;
      issue_pc_q <= '0;
    end else begin
      pc_q       <= pc_d;
      inflight_q <= inflight_d;
      issue_pc_q <= issue_pc_d;
    end
  end

  assign imem_rd_en = issue;
  assign imem_addr  = pc_q;

  fifo_instr #(
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .flush      (redirect),
    .push       (push),
    .push_instr (imem_data),
    .push_pc    (issue_pc_q),
    .pop        (pop),
    .head_instr (instr_out),
    .head_pc    (instr_pc),
    .head_valid (instr_valid),
    .count      (count)
  );

endmodule : unidad_fetch

// File: tb/tb_unidad_fetch.sv
// Bench for unidad_fetch: directed scenarios push expected {pc, word} pairs
// into a scoreboard; a negedge monitor compares every handshake transfer.
module tb_unidad_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_rd_en;
  logic [7:0]  imem_addr;
  logic [31:0] imem_data;
  logic [31:0] instr_out;
  logic [7:0]  instr_pc;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic        redirect    = 1'b0;
  logic [7:0]  redirect_pc = 8'h00;
  logic        halt        = 1'b0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0]  pc;
    logic [31:0] word;
  } exp_t;

  exp_t sb[$];

  unidad_fetch #(.ADDR_W(8), .RESET_PC(8'h00)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_rd_en  (imem_rd_en),
    .imem_addr   (imem_addr),
    .imem_data   (imem_data),
    .instr_out   (instr_out),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halt        (halt)
  );

  always #5 clk = ~clk;

  // Instruction memory contents: four program words, then a tagged pattern
  function automatic logic [31:0] mem_word(input logic [7:0] a);
    case (a)
      8'd0:    return 32'h0022_1820;
      8'd1:    return 32'h0022_1822;
      8'd2:    return 32'h8C01_0004;
      8'd3:    return 32'hAC01_0008;
      default: return {8'hC0, 16'h0000, a};
    endcase
  endfunction

  // Synchronous memory model, one cycle read latency
  always @(posedge clk) begin
    if (imem_rd_en) imem_data <= mem_word(imem_addr);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [7:0] pc);
    exp_t e;
    e.pc   = pc;
    e.word = mem_word(pc);
    sb.push_back(e);
  endtask

  task automatic go(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  // Reset the DUT; returns at the start of cycle 0 (first cycle after reset)
  task automatic start_test(input string name);
    rst         = 1'b1;
    instr_ready = 1'b0;
    halt        = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 8'h00;
    chk({name, "_prev_leftover"}, sb.size(), 0);
    sb.delete();
    go(2);
    rst = 1'b0;
  endtask

  // Monitor: every transfer must match the scoreboard head; occupancy bound
  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if (dut.u_fifo.count_q > 2'd2) begin
        errors++;
        $display("FAIL occupancy actual=%0d required<=2", dut.u_fifo.count_q);
      end
      if (instr_valid && instr_ready && !redirect) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_xfer actual pc=%h instr=%h required none", instr_pc, instr_out);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (instr_pc !== e.pc || instr_out !== e.word) begin
            errors++;
            $display("FAIL xfer actual pc=%h instr=%h required pc=%h instr=%h",
                     instr_pc, instr_out, e.pc, e.word);
          end else begin
            $display("xfer pc=%h instr=%h", instr_pc, instr_out);
          end
        end
      end
    end
  end

  initial begin
    // Reset state
    go(2);
    neg();
    chk("rst_valid", instr_valid, 0);
    chk("rst_instr", instr_out, 0);
    chk("rst_pc", instr_pc, 0);
    chk("rst_rd_en", imem_rd_en, 0);
    chk("rst_addr", imem_addr, 0);
    go(1);

    // T1: latency and full throughput
    start_test("t1");
    instr_ready = 1'b1;
    for (int i = 0; i < 10; i++) push_exp(8'(i));
    neg();
    chk("t1_c0_rd_en", imem_rd_en, 1);
    chk("t1_c0_addr", imem_addr, 0);
    chk("t1_c0_valid", instr_valid, 0);
    go(1);
    neg();
    chk("t1_c1_valid", instr_valid, 0);
    chk("t1_c1_addr", imem_addr, 1);
    go(1);
    for (int c = 2; c < 12; c++) begin
      neg();
      chk("t1_stream_valid", instr_valid, 1);
      go(1);
    end
    instr_ready = 1'b0;

    // T2: backpressure from reset, exactly two requests
    start_test("t2");
    for (int i = 0; i < 4; i++) push_exp(8'(i));
    for (int c = 0; c < 6; c++) begin
      neg();
      chk("t2_rd_en", imem_rd_en, (c < 2) ? 1 : 0);
      if (c == 5) chk("t2_count", dut.u_fifo.count_q, 2);
      go(1);
    end
    instr_ready = 1'b1;
    neg();
    chk("t2_resume_rd_en", imem_rd_en, 1);
    chk("t2_resume_addr", imem_addr, 2);
    go(4);
    instr_ready = 1'b0;

    // T3: redirect kills buffered and in-flight words
    start_test("t3");
    go(2);
    redirect    = 1'b1;
    redirect_pc = 8'h40;
    neg();
    chk("t3_redir_rd_en", imem_rd_en, 0);
    go(1);
    redirect    = 1'b0;
    instr_ready = 1'b1;
    for (int i = 0; i < 4; i++) push_exp(8'(8'h40 + i));
    neg();
    chk("t3_after_valid", instr_valid, 0);
    chk("t3_after_addr", imem_addr, 8'h40);
    chk("t3_after_rd_en", imem_rd_en, 1);
    go(6);
    instr_ready = 1'b0;

    // T4: back-to-back redirects, last one wins, PC wraps
    start_test("t4");
    instr_ready = 1'b1;
    go(1);
    redirect    = 1'b1;
    redirect_pc = 8'h10;
    go(1);
    redirect_pc = 8'hFE;
    go(1);
    redirect = 1'b0;
    push_exp(8'hFE);
    push_exp(8'hFF);
    push_exp(8'h00);
    push_exp(8'h01);
    neg();
    chk("t4_addr", imem_addr, 8'hFE);
    chk("t4_rd_en", imem_rd_en, 1);
    go(6);
    instr_ready = 1'b0;

    // T5: halt for five cycles in steady flow
    start_test("t5");
    instr_ready = 1'b1;
    for (int i = 0; i < 9; i++) push_exp(8'(i));
    go(6);
    halt = 1'b1;
    for (int c = 6; c < 11; c++) begin
      neg();
      chk("t5_halt_rd_en", imem_rd_en, 0);
      if (c == 8) chk("t5_drained_valid", instr_valid, 0);
      go(1);
    end
    halt = 1'b0;
    neg();
    chk("t5_resume_rd_en", imem_rd_en, 1);
    chk("t5_resume_addr", imem_addr, 6);
    go(5);
    instr_ready = 1'b0;

    // T6: reset while a request is in flight
    start_test("t6");
    instr_ready = 1'b1;
    push_exp(8'd0);
    push_exp(8'd1);
    go(4);
    rst = 1'b1;
    go(1);
    rst = 1'b0;
    chk("t6_pre_rst_leftover", sb.size(), 0);
    push_exp(8'd0);
    push_exp(8'd1);
    neg();
    chk("t6_c0_valid", instr_valid, 0);
    chk("t6_c0_addr", imem_addr, 0);
    go(1);
    neg();
    chk("t6_c1_valid", instr_valid, 0);
    go(1);
    neg();
    chk("t6_c2_valid", instr_valid, 1);
    chk("t6_c2_pc", instr_pc, 0);
    go(2);
    instr_ready = 1'b0;
    go(2);

    chk("final_leftover", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_unidad_fetch
